// File: rtl/custom_xif_ctrl.sv
// Issue/commit/result controller for a serial population-count coprocessor on the
// cv32e40x eXtension interface; one offloaded instruction in flight at a time.

package custom_instr_pkg;
    localparam logic [6:0] OPCODE_CNTB = 7'b0001011;
endpackage

module custom_xif_ctrl
    import custom_instr_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int ID_W    = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic [6:0]      issue_opcode_i,
    input  logic [4:0]      issue_rd_i,
    input  logic [31:0]     issue_rs1_i,
    input  logic [31:0]     issue_rs2_i,
    output logic            issue_accept_o,
    output logic            issue_writeback_o,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [4:0]      result_rd_o,
    output logic [31:0]     result_data_o,
    output logic            busy_o
);

    localparam int N = 32 / CHUNK_W;

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_COMMIT, RESULT} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     shift_q, shift_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [5:0]      chunk_q, chunk_d;
    logic            committed_q, committed_d;

    logic [5:0]      chunk_pc;
    logic            commit_hit;
    logic            last_chunk;
    logic            rs2_unused;

    assign rs2_unused = ^issue_rs2_i;

    always_comb begin
        chunk_pc = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            chunk_pc = chunk_pc + {5'b0, shift_q[i]};
        end
    end

    assign commit_hit = commit_valid_i && (commit_id_i == id_q);
    assign last_chunk = (chunk_q == 6'(N - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            id_q        <= '0;
            rd_q        <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            chunk_q     <= '0;
            committed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            rd_q        <= rd_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            chunk_q     <= chunk_d;
            committed_q <= committed_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        rd_d           = rd_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        chunk_d        = chunk_q;
        committed_d    = committed_q;
        issue_accept_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (issue_valid_i && issue_opcode_i == OPCODE_CNTB) begin
                    issue_accept_o = 1'b1;
                    id_d           = issue_id_i;
                    rd_d           = issue_rd_i;
                    shift_d        = issue_rs1_i;
                    cnt_d          = '0;
                    chunk_d        = '0;
                    committed_d    = 1'b0;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                // A kill aborts even on the final chunk.
                if (commit_hit && commit_kill_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + chunk_pc;
                    shift_d = shift_q >> CHUNK_W;
                    chunk_d = chunk_q + 6'd1;
                    if (commit_hit) committed_d = 1'b1;
                    if (last_chunk) begin
                        state_d = (committed_q || commit_hit) ? RESULT : WAIT_COMMIT;
                    end
                end
            end
            WAIT_COMMIT: begin
                if (commit_hit) begin
                    if (commit_kill_i) begin
                        state_d = IDLE;
                    end else begin
                        committed_d = 1'b1;
                        state_d     = RESULT;
                    end
                end
            end
            RESULT: begin
                if (result_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue_ready_o     = (state_q == IDLE);
    assign issue_writeback_o = issue_accept_o;
    assign result_valid_o    = (state_q == RESULT);
    assign result_id_o       = id_q;
    assign result_rd_o       = rd_q;
    assign result_data_o     = {26'b0, cnt_q};
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_custom_xif_ctrl.sv
// Directed bench for custom_xif_ctrl: CHUNK_W=8 main instance plus CHUNK_W=1/32 latency sweep.

module tb_custom_xif_ctrl;
    import custom_instr_pkg::*;

    localparam int ID_W = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            iv8, iv1, iv32;
    logic [ID_W-1:0] issue_id_i;
    logic [6:0]      issue_opcode_i;
    logic [4:0]      issue_rd_i;
    logic [31:0]     issue_rs1_i;
    logic [31:0]     issue_rs2_i;
    logic            commit_valid_i;
    logic [ID_W-1:0] commit_id_i;
    logic            commit_kill_i;
    logic            result_ready_i;

    logic            rdy8, acc8, wb8, rv8, busy8;
    logic [ID_W-1:0] rid8;
    logic [4:0]      rrd8;
    logic [31:0]     rdat8;
    logic            rdy1, acc1, wb1, rv1, busy1;
    logic [ID_W-1:0] rid1;
    logic [4:0]      rrd1;
    logic [31:0]     rdat1;
    logic            rdy32, acc32, wb32, rv32, busy32;
    logic [ID_W-1:0] rid32;
    logic [4:0]      rrd32;
    logic [31:0]     rdat32;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    custom_xif_ctrl #(.CHUNK_W(8), .ID_W(ID_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(iv8), .issue_ready_o(rdy8), .issue_id_i(issue_id_i),
        .issue_opcode_i(issue_opcode_i), .issue_rd_i(issue_rd_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_accept_o(acc8), .issue_writeback_o(wb8),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(rv8), .result_ready_i(result_ready_i), .result_id_o(rid8),
        .result_rd_o(rrd8), .result_data_o(rdat8), .busy_o(busy8)
    );

    custom_xif_ctrl #(.CHUNK_W(1), .ID_W(ID_W)) dut_c1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(iv1), .issue_ready_o(rdy1), .issue_id_i(issue_id_i),
        .issue_opcode_i(issue_opcode_i), .issue_rd_i(issue_rd_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_accept_o(acc1), .issue_writeback_o(wb1),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(rv1), .result_ready_i(result_ready_i), .result_id_o(rid1),
        .result_rd_o(rrd1), .result_data_o(rdat1), .busy_o(busy1)
    );

    custom_xif_ctrl #(.CHUNK_W(32), .ID_W(ID_W)) dut_c32 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(iv32), .issue_ready_o(rdy32), .issue_id_i(issue_id_i),
        .issue_opcode_i(issue_opcode_i), .issue_rd_i(issue_rd_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_accept_o(acc32), .issue_writeback_o(wb32),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(rv32), .result_ready_i(result_ready_i), .result_id_o(rid32),
        .result_rd_o(rrd32), .result_data_o(rdat32), .busy_o(busy32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic offer(input logic [ID_W-1:0] id, input logic [6:0] op,
                         input logic [4:0] rd, input logic [31:0] rs1);
        issue_id_i     = id;
        issue_opcode_i = op;
        issue_rd_i     = rd;
        issue_rs1_i    = rs1;
        issue_rs2_i    = 32'hDEAD_BEEF;
    endtask

    task automatic commit(input logic v, input logic [ID_W-1:0] id, input logic kill);
        commit_valid_i = v;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    int lat1, lat32;
    logic [31:0] d1, d32;

    initial begin
        rst_ni = 1'b0;
        iv8 = 1'b0; iv1 = 1'b0; iv32 = 1'b0;
        offer('0, 7'h0, '0, '0);
        commit(1'b0, '0, 1'b0);
        result_ready_i = 1'b1;

        // reset state
        smp();
        chk("rst_ready", rdy8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_rvalid", rv8, 0);
        chk("rst_data", rdat8, 0);
        chk("rst_accept", acc8, 0);
        cyc();
        rst_ni = 1'b1;
        cyc();

        // accept path: 0xF0F0_0001 -> 9, commit at cycle 2
        offer(4'd3, OPCODE_CNTB, 5'd5, 32'hF0F0_0001); iv8 = 1'b1;
        smp(); chk("acc_ready", rdy8, 1); chk("acc_accept", acc8, 1); chk("acc_wb", wb8, 1);
        cyc();                                   // cycle 1: offer while busy
        smp(); chk("busy_ready", rdy8, 0); chk("busy_accept", acc8, 0); chk("busy_c1", busy8, 1);
        cyc(); iv8 = 1'b0; commit(1'b1, 4'd3, 1'b0);
        smp(); chk("acc_rv_c2", rv8, 0);
        cyc(); commit(1'b0, '0, 1'b0);
        cyc(); smp(); chk("acc_rv_c4", rv8, 0);
        cyc(); smp();
        chk("acc_rv_c5", rv8, 1); chk("acc_data", rdat8, 9);
        chk("acc_id", rid8, 3); chk("acc_rd", rrd8, 5);
        cyc(); smp(); chk("acc_busy_c6", busy8, 0); chk("acc_ready_c6", rdy8, 1);

        // reject unknown opcode
        offer(4'd1, 7'h33, 5'd2, 32'h1234_5678); iv8 = 1'b1;
        smp(); chk("rej_ready", rdy8, 1); chk("rej_accept", acc8, 0); chk("rej_wb", wb8, 0);
        cyc(); iv8 = 1'b0;
        smp(); chk("rej_busy", busy8, 0); chk("rej_rv", rv8, 0);
        cyc();

        // late commit, foreign-id filtering, backpressure
        offer(4'd7, OPCODE_CNTB, 5'd10, 32'hFFFF_FFFF); iv8 = 1'b1; result_ready_i = 1'b0;
        smp(); chk("late_accept", acc8, 1);
        cyc(); iv8 = 1'b0;
        cyc(); cyc(); cyc();
        cyc(); smp(); chk("late_busy_c5", busy8, 1); chk("late_rv_c5", rv8, 0);
        cyc(); commit(1'b1, 4'd2, 1'b0);
        smp(); chk("late_rv_c6", rv8, 0);
        cyc(); commit(1'b0, '0, 1'b0);
        smp(); chk("filt_busy_c7", busy8, 1); chk("filt_rv_c7", rv8, 0);
        cyc(); commit(1'b1, 4'd7, 1'b0);
        smp(); chk("late_rv_c8", rv8, 0);
        cyc(); commit(1'b0, '0, 1'b0);
        smp(); chk("late_rv_c9", rv8, 1); chk("late_data_c9", rdat8, 32);
        chk("late_id", rid8, 7); chk("late_rd", rrd8, 10);
        cyc(); smp(); chk("bp_rv_c10", rv8, 1); chk("bp_data_c10", rdat8, 32);
        cyc(); smp(); chk("bp_rv_c11", rv8, 1); chk("bp_data_c11", rdat8, 32);
        cyc(); result_ready_i = 1'b1;
        smp(); chk("bp_rv_c12", rv8, 1);
        cyc(); smp(); chk("bp_busy_c13", busy8, 0);
        cyc();

        // kill at cycle 3
        offer(4'd7, OPCODE_CNTB, 5'd1, 32'h0000_00FF); iv8 = 1'b1;
        cyc(); iv8 = 1'b0;
        cyc();
        cyc(); commit(1'b1, 4'd7, 1'b1);
        smp(); chk("kill3_busy_c3", busy8, 1);
        cyc(); commit(1'b0, '0, 1'b0);
        smp(); chk("kill3_busy_c4", busy8, 0); chk("kill3_ready_c4", rdy8, 1);
        cyc(); smp(); chk("kill3_rv_c5", rv8, 0);
        cyc(); smp(); chk("kill3_rv_c6", rv8, 0);
        cyc();

        // kill on the final BUSY cycle, after an earlier commit
        offer(4'd7, OPCODE_CNTB, 5'd1, 32'h0000_00FF); iv8 = 1'b1;
        cyc(); iv8 = 1'b0;
        cyc(); commit(1'b1, 4'd7, 1'b0);
        cyc(); commit(1'b0, '0, 1'b0);
        cyc(); commit(1'b1, 4'd7, 1'b1);
        smp(); chk("kill4_busy_c4", busy8, 1);
        cyc(); commit(1'b0, '0, 1'b0);
        smp(); chk("kill4_busy_c5", busy8, 0); chk("kill4_rv_c5", rv8, 0);
        cyc(); smp(); chk("kill4_rv_c6", rv8, 0);
        cyc();

        // rs1 = 0
        offer(4'd1, OPCODE_CNTB, 5'd1, 32'h0); iv8 = 1'b1;
        cyc(); iv8 = 1'b0; commit(1'b1, 4'd1, 1'b0);
        cyc(); commit(1'b0, '0, 1'b0);
        cyc(); cyc();
        cyc(); smp(); chk("zero_rv", rv8, 1); chk("zero_data", rdat8, 0); chk("zero_id", rid8, 1);
        cyc(); cyc();

        // reset in BUSY
        offer(4'd5, OPCODE_CNTB, 5'd6, 32'h0000_00FF); iv8 = 1'b1;
        cyc(); iv8 = 1'b0; commit(1'b1, 4'd5, 1'b0);
        cyc(); commit(1'b0, '0, 1'b0); rst_ni = 1'b0;
        #1;
        chk("mrst_busy", busy8, 0); chk("mrst_ready", rdy8, 1); chk("mrst_rv", rv8, 0);
        chk("mrst_id", rid8, 0); chk("mrst_rd", rrd8, 0); chk("mrst_data", rdat8, 0);
        cyc(); rst_ni = 1'b1;
        cyc(); cyc(); smp(); chk("mrst_rv_after", rv8, 0); chk("mrst_busy_after", busy8, 0);
        cyc();

        // CHUNK_W sweep: 0xA5A5_A5A5 -> 16; latency 33 (CHUNK_W=1) and 2 (CHUNK_W=32)
        offer(4'd4, OPCODE_CNTB, 5'd9, 32'hA5A5_A5A5); iv1 = 1'b1; iv32 = 1'b1;
        smp(); chk("sw1_accept", acc1, 1); chk("sw32_accept", acc32, 1);
        cyc(); iv1 = 1'b0; iv32 = 1'b0; commit(1'b1, 4'd4, 1'b0);
        lat1 = -1; lat32 = -1; d1 = '0; d32 = '0;
        for (int c = 1; c <= 40; c++) begin
            smp();
            if (rv1 && lat1 < 0) begin lat1 = c; d1 = rdat1; end
            if (rv32 && lat32 < 0) begin lat32 = c; d32 = rdat32; end
            cyc();
            commit(1'b0, '0, 1'b0);
        end
        chk("sw1_latency", lat1, 33); chk("sw1_data", d1, 16);
        chk("sw32_latency", lat32, 2); chk("sw32_data", d32, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/custom_xif_ctrl.md
Name: custom_xif_ctrl

Overview:
- Issue/commit/result controller for the custom-instruction coprocessor attached to the cv32e40x eXtension interface.
- Decodes offloaded instructions against custom_instr_pkg opcodes and accepts OPCODE_CNTB (population count of rs1).
- Sequences a serial bit-count datapath, CHUNK_W bits per cycle, and tracks commit/kill from the core.
- Returns the result through a valid/ready result channel; one instruction is outstanding at a time.

Parameters:
- CHUNK_W, 8, bits of rs1 counted per BUSY cycle; legal values 1, 2, 4, 8, 16, 32; N = 32/CHUNK_W.
- ID_W, 4, width of the instruction ID carried on issue, commit and result.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  core offers an instruction
- issue_ready_o  out  1  issue handshake completes when valid && ready
- issue_id_i  in  ID_W  instruction ID
- issue_opcode_i  in  7  major opcode
- issue_rd_i  in  5  destination register
- issue_rs1_i  in  32  operand 1
- issue_rs2_i  in  32  operand 2; ignored for CNTB
- issue_accept_o  out  1  instruction accepted; meaningful only during the handshake
- issue_writeback_o  out  1  instruction will write rd; equals issue_accept_o
- commit_valid_i  in  1  commit/kill strobe
- commit_id_i  in  ID_W  ID being committed or killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes the result
- result_id_o  out  ID_W  ID of the result
- result_rd_o  out  5  destination register
- result_data_o  out  32  popcount, zero-extended
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0 except issue_ready_o, which is combinational and equals 1 in IDLE; internal registers 0. Reset mid-operation drops the instruction with no result.
- States: IDLE, BUSY, WAIT_COMMIT, RESULT. Registers: id_q, rd_q, shift_q[31:0], cnt_q[5:0], chunk_q, committed_q.
- issue_ready_o = (state==IDLE). Unknown opcodes complete the handshake with issue_accept_o=0 and issue_writeback_o=0, and state stays IDLE.
- IDLE -> BUSY on handshake with opcode==OPCODE_CNTB:
  - issue_accept_o=1 and issue_writeback_o=1 combinationally in that cycle.
  - Latch id, rd and rs1; set cnt_q=0, chunk_q=0, committed_q=0.
- BUSY, each cycle:
  - cnt_q += popcount(shift_q[CHUNK_W-1:0]).
  - shift_q >>= CHUNK_W.
  - chunk_q++.
  - On the Nth BUSY cycle, go to RESULT if committed_q, or if a matching commit arrives that same cycle; otherwise go to WAIT_COMMIT.
- Commit handling in BUSY and WAIT_COMMIT, applied only when commit_valid_i && commit_id_i==id_q:
  - kill=0: set committed_q. In WAIT_COMMIT, go to RESULT next cycle.
  - kill=1: go to IDLE next cycle, no result, cnt discarded. Kill takes priority over completion in the same cycle.
  - Non-matching IDs are ignored.
- Commit in the issue-handshake cycle is ignored. The core must not commit before issue completes.
- RESULT:
  - result_valid_o=1; id, rd and data are stable until result_valid_o && result_ready_i, then go to IDLE.
  - Commit inputs are ignored.
  - No new issue is accepted until the next cycle, because issue_ready_o=0 in RESULT.
- Latency: handshake in cycle 0; BUSY occupies cycles 1..N; result_valid_o is earliest in cycle N+1, i.e. cycle 5 for CHUNK_W=8.
- Width: cnt_q is 6 bits (max 32); result_data_o = {26'b0, cnt_q}.

Test Plan:
- Accept path: CHUNK_W=8, issue CNTB with id=3, rd=5, rs1=0xF0F0_0001, commit id=3 at cycle 2, result_ready_i=1 -> accept=1 at cycle 0; result_valid_o at cycle 5 with data=9, id=3, rd=5; busy_o=0 at cycle 6.
- Reject: issue opcode != OPCODE_CNTB -> ready=1, accept=0, writeback=0; busy_o stays 0; no result.
- Late commit and backpressure: rs1=0xFFFF_FFFF, commit at cycle 8, result_ready_i held 0 for 3 cycles -> WAIT_COMMIT during cycles 5-8; result_valid_o from cycle 9 with data=32 held stable; IDLE after the ready cycle.
- Kill: issue id=7, kill id=7 at cycle 3 -> IDLE at cycle 4, no result_valid_o. Repeat with kill in cycle 4 (the Nth BUSY cycle) -> kill wins, no result.
- Filtering: commit with id=2 while id_q=7 -> ignored, stays in WAIT_COMMIT. Issue offered while busy -> issue_ready_o=0. rs1=0 -> data=0.
- Reset: assert rst_ni low in BUSY -> all outputs 0 (issue_ready_o=1 in IDLE) immediately. Sweep CHUNK_W in {1, 32} -> result latency N+1 = 33 and 2 cycles respectively.
